// File: rtl/fp_pipe_sequencer.sv
// ---------------------------------------------------------------------------
// fp_pipe_sequencer
//
// Issue/collect front end for the 5-stage FP execute pipeline (fx1..fx5).
// Requests arrive on a valid/ready port and are registered onto the of_*
// operand-fetch outputs. A {valid,tag} shift register follows each operation
// down the pipe. When the tag pipe's last stage is valid, lanes 0-3 of the
// fx5 result are captured into a response FIFO, which returns results in
// issue order with valid/ready backpressure.
//
// Optional feature: define FP_SEQ_PERF_EN to add 32-bit wrapping performance
// counters perf_issued / perf_retired / perf_stall.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b       alu op and operand lanes 0-3 (lane n = [32n+31:32n])
//   req_tag                    opaque id returned with the result
//   of_instruction_valid       one-cycle pulse per accepted request
//   of_instruction_i           registered req_op
//   of_pipeline_sel            constant PIPE_FP_ARITH
//   of_operand1/2              registered req_a/req_b
//   of_mask_value              constant 16'hFFFF
//   fx5_instruction_valid      result valid from fx5
//   fx5_result_lo              fx5 result lanes 0-3
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_tag        response payload
//   perf_*                     (FP_SEQ_PERF_EN only) accepts, pops, stall cycles
//   protocol_error             sticky: fx5 valid disagreed with the tag pipe
// ---------------------------------------------------------------------------
module fp_pipe_sequencer #(
    parameter int         FP_LATENCY    = 5,
    parameter int         FIFO_DEPTH    = 8,
    parameter int         TAG_WIDTH     = 8,
    parameter logic [1:0] PIPE_FP_ARITH = 2'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_op,
    input  logic [127:0]         req_a,
    input  logic [127:0]         req_b,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 of_instruction_valid,
    output logic [5:0]           of_instruction_i,
    output logic [1:0]           of_pipeline_sel,
    output logic [127:0]         of_operand1,
    output logic [127:0]         of_operand2,
    output logic [15:0]          of_mask_value,
    input  logic                 fx5_instruction_valid,
    input  logic [127:0]         fx5_result_lo,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_result,
    output logic [TAG_WIDTH-1:0] rsp_tag,
`ifdef FP_SEQ_PERF_EN
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_retired,
    output logic [31:0]          perf_stall,
`endif
    output logic                 protocol_error
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 128 + TAG_WIDTH;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    // Stage 0 is the of_* register itself; stage FP_LATENCY lines up with fx5.
    logic [FP_LATENCY:0] pipe_valid;
    logic [TAG_WIDTH-1:0] pipe_tag [FP_LATENCY+1];

    // Response storage: a RAM plus an output register that holds the head.
    // rsp_valid marks the output register as occupied, so total occupancy is
    // mem_count + rsp_valid.
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   mem_count;

    logic               accept;
    logic               push;
    logic               pop;
    logic               out_load;
    logic               take_mem;
    logic               bypass;
    logic               mem_write;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     used;

    assign of_pipeline_sel      = PIPE_FP_ARITH;
    assign of_mask_value        = 16'hFFFF;
    assign of_instruction_valid = pipe_valid[0];

    assign push      = pipe_valid[FP_LATENCY];
    assign pop       = rsp_valid & rsp_ready;
    assign out_load  = ~rsp_valid | pop;
    assign take_mem  = out_load & (mem_count != '0);
    // Empty RAM and free output register: a capture goes straight to the output.
    assign bypass    = out_load & (mem_count == '0) & push;
    assign mem_write = push & ~bypass;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= FP_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_valid[i]);
        end
    end

    assign fifo_count = mem_count + CNT_W'(rsp_valid);
    assign used       = {1'b0, fifo_count} + {1'b0, inflight};
    // A pop this cycle frees a slot immediately, so it reopens req_ready.
    assign req_ready  = (used != DEPTH_V) | pop;
    assign accept     = req_valid & req_ready;

    // Issue register and tag pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            of_instruction_i <= '0;
            of_operand1      <= '0;
            of_operand2      <= '0;
            pipe_valid       <= '0;
            for (int i = 0; i <= FP_LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid <= {pipe_valid[FP_LATENCY-1:0], accept};
            for (int i = 1; i <= FP_LATENCY; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end
            if (accept) begin
                of_instruction_i <= req_op;
                of_operand1      <= req_a;
                of_operand2      <= req_b;
                pipe_tag[0]      <= req_tag;
            end
        end
    end

    // RAM write port kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr] <= {fx5_result_lo, pipe_tag[FP_LATENCY]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            mem_count      <= '0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_tag        <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (mem_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (take_mem) begin
                {rsp_result, rsp_tag} <= mem[rd_ptr];
                rd_ptr                <= rd_ptr + PTR_W'(1);
            end else if (bypass) begin
                rsp_result <= fx5_result_lo;
                rsp_tag    <= pipe_tag[FP_LATENCY];
            end
            // Output register keeps its payload when drained empty.
            if (out_load) begin
                rsp_valid <= take_mem | bypass;
            end
            mem_count <= mem_count + CNT_W'(mem_write) - CNT_W'(take_mem);
            if (fx5_instruction_valid != pipe_valid[FP_LATENCY]) begin
                protocol_error <= 1'b1;
            end
        end
    end

`ifdef FP_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued  <= '0;
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (accept) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (pop) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (req_valid & ~req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_pipe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fp_pipe_sequencer
//
// Scoreboard bench: accepted requests push their expected response into a
// queue; a monitor thread pops and compares whenever a response handshake
// occurs. A behavioural FP pipe model feeds fx5 from the of_* outputs.
// Build with FP_SEQ_PERF_EN defined to also check the perf counters.
// ---------------------------------------------------------------------------
module tb_fp_pipe_sequencer;

    localparam int L  = 5;
    localparam int D  = 8;
    localparam int TW = 8;
    localparam logic [5:0] OP_ADD_F = 6'h01;
    localparam logic [5:0] OP_MUL_F = 6'h03;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_op;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [TW-1:0] req_tag;
    logic          of_instruction_valid;
    logic [5:0]    of_instruction_i;
    logic [1:0]    of_pipeline_sel;
    logic [127:0]  of_operand1;
    logic [127:0]  of_operand2;
    logic [15:0]   of_mask_value;
    logic          fx5_instruction_valid;
    logic [127:0]  fx5_result_lo;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [127:0]  rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          protocol_error;
`ifdef FP_SEQ_PERF_EN
    logic [31:0]   perf_issued;
    logic [31:0]   perf_retired;
    logic [31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    fp_pipe_sequencer #(.FP_LATENCY(L), .FIFO_DEPTH(D), .TAG_WIDTH(TW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_op                (req_op),
        .req_a                 (req_a),
        .req_b                 (req_b),
        .req_tag               (req_tag),
        .of_instruction_valid  (of_instruction_valid),
        .of_instruction_i      (of_instruction_i),
        .of_pipeline_sel       (of_pipeline_sel),
        .of_operand1           (of_operand1),
        .of_operand2           (of_operand2),
        .of_mask_value         (of_mask_value),
        .fx5_instruction_valid (fx5_instruction_valid),
        .fx5_result_lo         (fx5_result_lo),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_result            (rsp_result),
        .rsp_tag               (rsp_tag),
`ifdef FP_SEQ_PERF_EN
        .perf_issued           (perf_issued),
        .perf_retired          (perf_retired),
        .perf_stall            (perf_stall),
`endif
        .protocol_error        (protocol_error)
    );

    // Stand-in for the FP pipe: lane 0 of the two directed cases carries the
    // hand-computed IEEE result, every other lane is a^b.
    function automatic logic [127:0] exp_result(input logic [5:0] op,
                                                input logic [127:0] a,
                                                input logic [127:0] b);
        logic [31:0] l0;
        if (op == OP_ADD_F && a[31:0] == 32'h3F800000 && b[31:0] == 32'h40000000)
            l0 = 32'h40400000;      // 1.0 + 2.0 = 3.0
        else if (op == OP_MUL_F && a[31:0] == 32'h40000000 && b[31:0] == 32'h40400000)
            l0 = 32'h40C00000;      // 2.0 * 3.0 = 6.0
        else
            l0 = a[31:0] ^ b[31:0];
        return {a[127:32] ^ b[127:32], l0};
    endfunction

    // FP pipe model: L cycles from of_instruction_valid to fx5.
    logic          m_valid [L];
    logic [127:0]  m_res   [L];
    logic          fx5_force;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++) m_valid[k] <= 1'b0;
        end else begin
            m_valid[0] <= of_instruction_valid;
            m_res[0]   <= exp_result(of_instruction_i, of_operand1, of_operand2);
            for (int k = 1; k < L; k++) begin
                m_valid[k] <= m_valid[k-1];
                m_res[k]   <= m_res[k-1];
            end
        end
    end

    assign fx5_instruction_valid = m_valid[L-1] | fx5_force;
    assign fx5_result_lo         = m_res[L-1];

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        logic [127:0]  res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   pop_cycles[$];
    int   passed   = 0;
    int   total    = 0;
    int   accepts  = 0;
    int   pops     = 0;
    int   stalls   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got === want) begin
            passed++;
            $display("check %s: %0h ok", name, got);
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        fx5_force = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 128'(q.size()), 128'd0);
    endtask

    int t0;
    int p0;
    int n;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        fx5_force = 1'b0;

        // Monitor / scoreboard thread.
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    q.delete();
                    pop_cycles.delete();
                    accepts = 0;
                    pops    = 0;
                    stalls  = 0;
                end else begin
                    if (req_valid && !req_ready) stalls++;
                    if (rsp_valid && rsp_ready) begin
                        total++;
                        if (q.size() == 0) begin
                            $display("FAIL rsp_unexpected: got tag %0h result %0h, required no response",
                                     rsp_tag, rsp_result);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            if (rsp_result === e.res && rsp_tag === e.tag) begin
                                passed++;
                                $display("rsp tag=%0h result=%0h ok", rsp_tag, rsp_result);
                            end else begin
                                $display("FAIL rsp_data: got tag %0h result %0h, required tag %0h result %0h",
                                         rsp_tag, rsp_result, e.tag, e.res);
                            end
                        end
                        pops++;
                        pop_cycles.push_back(cycle_cnt);
                    end
                    if (req_valid && req_ready) begin
                        q.push_back('{res: exp_result(req_op, req_a, req_b), tag: req_tag});
                        accepts++;
                        $display("req tag=%0h op=%0h accepted", req_tag, req_op);
                    end
                end
            end
        join_none

        tick();
        tick();
        reset = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_of_valid", 128'(of_instruction_valid), 128'd0);
        check("rst_pipe_sel", 128'(of_pipeline_sel), 128'd1);
        check("rst_mask", 128'(of_mask_value), 128'hFFFF);
        check("rst_perr", 128'(protocol_error), 128'd0);
        check("rst_rsp_result", rsp_result, 128'd0);
        check("rst_operand1", of_operand1, 128'd0);

        // 1: single add, latency check.
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_ADD_F;
        req_a     = {32'h1, 32'h2, 32'h3, 32'h3F800000};
        req_b     = {32'h10, 32'h20, 32'h30, 32'h40000000};
        req_tag   = 8'h11;
        @(negedge clk);
        t0 = cycle_cnt;
        check("t1_req_ready", 128'(req_ready), 128'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("t1_of_valid", 128'(of_instruction_valid), 128'd1);
        check("t1_of_op", 128'(of_instruction_i), 128'(OP_ADD_F));
        check("t1_of_operand1", of_operand1, {32'h1, 32'h2, 32'h3, 32'h3F800000});
        check("t1_of_operand2", of_operand2, {32'h10, 32'h20, 32'h30, 32'h40000000});
        @(negedge clk);
        check("t1_of_valid_drop", 128'(of_instruction_valid), 128'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_rsp_latency", 128'(cycle_cnt - t0), 128'(L + 2));
        wait_drain("t1_drain");

        // 2: 8 back-to-back multiplies.
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 1'b1;
            req_op    = OP_MUL_F;
            req_a     = {96'h0, 32'h40000000};
            req_b     = {96'h0, 32'h40400000};
            req_tag   = TW'(i);
        end
        tick();
        req_valid = 1'b0;
        wait_drain("t2_drain");
        check("t2_pop_count", 128'(pops - p0), 128'd8);
        if (pops - p0 == 8)
            check("t2_consecutive", 128'(pop_cycles[p0 + 7] - pop_cycles[p0]), 128'd7);
        check("t2_perr", 128'(protocol_error), 128'd0);

        // 3: fill to credit limit, single pop releases one accept.
        do_reset();
        req_valid = 1'b1;
        req_op    = OP_ADD_F;
        req_a     = {96'h0, 32'h12345678};
        req_b     = {96'h0, 32'h0F0F0F0F};
        for (int i = 0; i < 20; i++) begin
            req_tag = TW'(8'h30 + i);
            tick();
        end
        check("t3_accepts_full", 128'(accepts), 128'd8);
        check("t3_ready_full", 128'(req_ready), 128'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_on_pop", 128'(req_ready), 128'd1);
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_tag = TW'(8'h50 + i);
            tick();
        end
        check("t3_accepts_total", 128'(accepts), 128'd9);
        check("t3_ready_refull", 128'(req_ready), 128'd0);
`ifdef FP_SEQ_PERF_EN
        check("t6_perf_issued", 128'(perf_issued), 128'd9);
        check("t6_perf_retired", 128'(perf_retired), 128'd1);
        check("t6_perf_stall", 128'(perf_stall), 128'(stalls));
`endif
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("t3_drain");

        // 4: spurious fx5 valid.
        do_reset();
        fx5_force = 1'b1;
        @(negedge clk);
        check("t4_perr_before", 128'(protocol_error), 128'd0);
        tick();
        fx5_force = 1'b0;
        @(negedge clk);
        check("t4_perr_set", 128'(protocol_error), 128'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t4_perr_sticky", 128'(protocol_error), 128'd1);
        check("t4_no_capture", 128'(rsp_valid), 128'd0);
        do_reset();
        check("t4_perr_cleared", 128'(protocol_error), 128'd0);

        // 5: reset with 2 in FIFO and 3 in flight.
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_op    = OP_MUL_F;
            req_a     = {96'h0, 32'h40000000};
            req_b     = {96'h0, 32'h40400000};
            req_tag   = TW'(8'hA0 + i);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < L + 3; i++) tick();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_tag   = TW'(8'hB0 + i);
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("t5_pre_rsp_valid", 128'(rsp_valid), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("t5_rst_of_valid", 128'(of_instruction_valid), 128'd0);
        check("t5_rst_req_ready", 128'(req_ready), 128'd1);
        check("t5_rst_pipe_sel", 128'(of_pipeline_sel), 128'd1);
        check("t5_rst_mask", 128'(of_mask_value), 128'hFFFF);
        check("t5_rst_rsp_tag", 128'(rsp_tag), 128'd0);
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("t5_no_rsp", 128'(pops), 128'd0);
        check("t5_req_ready", 128'(req_ready), 128'd1);
        check("t5_perr", 128'(protocol_error), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
